// File: rtl/pipe_pkg.sv
// Shared types and default widths for elastic pipeline stage registers.
package pipe_pkg;

    localparam int DATA_W_DEF = 160;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic occ_e occ_of(input logic m_valid, input logic s_valid);
        return occ_e'({1'b0, m_valid} + {1'b0, s_valid});
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot (valid + payload + control) with load, drop and masked kill.
module pipe_slot #(
    parameter int                DATA_W    = 160,
    parameter int                CTRL_W    = 16,
    parameter logic [CTRL_W-1:0] KILL_MASK = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drop,
    input  logic              kill,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // NOTE: payload is cleared on reset too, so a reset stage shows all-zero outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (kill) begin
            // Kill keeps the payload; only masked control bits are squashed.
            valid <= 1'b0;
            ctrl  <= ctrl & ~KILL_MASK;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/elastic_stage_reg.sv
// Valid/ready pipeline stage register with optional skid slot, hold, flush and perf counters.
module elastic_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                CTRL_W    = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] KILL_MASK = '1,
    parameter int                SKID      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] s_data, m_load_data;
    logic [CTRL_W-1:0] s_ctrl, m_load_ctrl;
    logic              normal, kill;
    logic              in_fire, out_fire;
    logic              m_load, m_drop, s_load, s_drop;
    occ_e              occ;

    assign normal = ~reset & ~hold & ~flush;
    assign kill   = ~hold & flush;

    // Skid mode readiness comes only from the registered S.valid, breaking the ready chain.
    assign in_ready  = normal & ((SKID != 0) ? ~s_valid : (~m_valid | out_ready));
    assign out_valid = ~reset & ~hold & m_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & normal;

    always_comb begin
        m_load = 1'b0;
        m_drop = 1'b0;
        s_load = 1'b0;
        s_drop = 1'b0;
        if (SKID != 0) begin
            m_load = (s_valid & out_fire) | (in_fire & (~m_valid | out_fire));
            s_load = in_fire & m_valid & ~out_fire;
            s_drop = s_valid & out_fire;
        end else begin
            m_load = in_fire;
        end
        m_drop = out_fire & ~m_load;
    end

    // When S is occupied it is always the older entry, so it refills M first.
    assign m_load_data = s_valid ? s_data : in_data;
    assign m_load_ctrl = s_valid ? s_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .KILL_MASK(KILL_MASK)) u_m (
        .clk       (clk),
        .reset     (reset),
        .load      (m_load),
        .drop      (m_drop),
        .kill      (kill),
        .load_data (m_load_data),
        .load_ctrl (m_load_ctrl),
        .valid     (m_valid),
        .data      (out_data),
        .ctrl      (out_ctrl)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .KILL_MASK(KILL_MASK)) u_s (
            .clk       (clk),
            .reset     (reset),
            .load      (s_load),
            .drop      (s_drop),
            .kill      (kill),
            .load_data (in_data),
            .load_ctrl (in_ctrl),
            .valid     (s_valid),
            .data      (s_data),
            .ctrl      (s_ctrl)
        );
    end else begin : g_no_skid
        assign s_valid = 1'b0;
        assign s_data  = '0;
        assign s_ctrl  = '0;
    end

    assign occ       = occ_of(m_valid, s_valid);
    assign occupancy = occ;

    // NOTE: counters are sequential state, so they use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (hold)     stall_cnt <= stall_cnt + CNT_W'(1);
            if (kill)     flush_cnt <= flush_cnt + CNT_W'(1);
            if (out_fire) xfer_cnt  <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed self-checking bench for elastic_stage_reg (skid and non-skid builds).
module tb_elastic_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, hold, flush;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt, flush_cnt, xfer_cnt;

    logic          i0_valid, i0_ready, o0_valid, o0_ready;
    logic [DW-1:0] i0_data, o0_data;
    logic [CW-1:0] o0_ctrl;
    logic [1:0]    occ0;
    logic [31:0]   st0, fl0, xf0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    elastic_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(16'h00F0), .SKID(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .xfer_cnt(xfer_cnt)
    );

    elastic_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(i0_valid), .in_ready(i0_ready),
        .in_data(i0_data), .in_ctrl(16'h0001), .hold(hold), .flush(flush),
        .out_valid(o0_valid), .out_ready(o0_ready), .out_data(o0_data),
        .out_ctrl(o0_ctrl), .occupancy(occ0), .stall_cnt(st0),
        .flush_cnt(fl0), .xfer_cnt(xf0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
        i0_valid = 1'b0; o0_ready = 1'b0; i0_data = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_xfer", xfer_cnt, 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);

        // Non-skid build: in_ready follows out_ready combinationally once M is full.
        i0_valid = 1'b1; i0_data = 32'h0000_00C1;
        #1 check("ns_ready_empty", 32'(i0_ready), 32'd1);
        step();
        i0_data = 32'h0000_00C2;
        #1 check("ns_ready_full_blocked", 32'(i0_ready), 32'd0);
        check("ns_out_data", o0_data, 32'h0000_00C1);
        o0_ready = 1'b1;
        #1 check("ns_ready_passthru", 32'(i0_ready), 32'd1);
        step();
        i0_valid = 1'b0; o0_ready = 1'b0;
        #1 check("ns_out_data2", o0_data, 32'h0000_00C2);
        check("ns_xfer", xf0, 32'd1);

        // Streaming 1..8 with out_ready high.
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'd1;
        step();
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("stream_data_%0d", i - 1), out_data, 32'(i - 1));
            check($sformatf("stream_occ_%0d", i - 1), 32'(occupancy), 32'd1);
            if (i == 9) in_valid = 1'b0;
            in_data = 32'(i);
            step();
        end
        check("stream_xfer", xfer_cnt, 32'd8);
        check("stream_drain_occ", 32'(occupancy), 32'd0);

        // Skid fill and drain.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_000A;
        step();
        check("skid_ready_one", 32'(in_ready), 32'd1);
        in_data = 32'h0000_000B;
        step();
        in_valid = 1'b0;
        #1;
        check("skid_occ2", 32'(occupancy), 32'd2);
        check("skid_ready_full", 32'(in_ready), 32'd0);
        check("skid_out_a", out_data, 32'h0000_000A);
        out_ready = 1'b1;
        step();
        check("skid_out_b", out_data, 32'h0000_000B);
        check("skid_occ1", 32'(occupancy), 32'd1);
        step();
        check("skid_occ0", 32'(occupancy), 32'd0);
        check("skid_xfer", xfer_cnt, 32'd10);

        // Flush squashes masked ctrl bits, keeps data, and does not count the transfer.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0055; in_ctrl = 16'hFFFF;
        step();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_out_valid_same", 32'(out_valid), 32'd1);
        step();
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_ctrl", 32'(out_ctrl), 32'h0000_FF0F);
        check("flush_data", out_data, 32'h0000_0055);
        check("flush_cnt", flush_cnt, 32'd1);
        check("flush_xfer", xfer_cnt, 32'd10);

        // Hold wins over flush; contents frozen for three cycles.
        in_valid = 1'b1; in_data = 32'h0000_0077; in_ctrl = 16'h1234;
        step();
        in_valid = 1'b0; hold = 1'b1; flush = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold_out_valid_%0d", i), 32'(out_valid), 32'd0);
            step();
        end
        hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        check("hold_valid_kept", 32'(out_valid), 32'd1);
        check("hold_ctrl_kept", 32'(out_ctrl), 32'h0000_1234);
        check("hold_data_kept", out_data, 32'h0000_0077);
        check("hold_stall_cnt", stall_cnt, 32'd3);
        check("hold_flush_cnt", flush_cnt, 32'd1);

        // Reset with both slots occupied.
        in_valid = 1'b1; in_data = 32'h0000_0088;
        step();
        check("pre_rst_occ", 32'(occupancy), 32'd2);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("postrst_occ", 32'(occupancy), 32'd0);
        check("postrst_data", out_data, 32'd0);
        check("postrst_ctrl", 32'(out_ctrl), 32'd0);
        check("postrst_stall", stall_cnt, 32'd0);
        check("postrst_flush", flush_cnt, 32'd0);
        check("postrst_xfer", xfer_cnt, 32'd0);

        // Stall counter wraps.
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        hold = 1'b1;
        step();
        hold = 1'b0;
        check("stall_wrap", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
